// File: rtl/inst_mem_loader.sv
// Writable 32 x 16-bit instruction memory filled from a big-endian byte stream.
// Define INST_LOADER_CHECKSUM_EN to consume and verify one trailing checksum byte.
module inst_mem_loader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  wordCountM1,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  input  logic [4:0]  address,
  output logic [15:0] instruction,
  output logic        loading,
  output logic        cpuHold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StRxHi,
    StRxLo,
`ifdef INST_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        done_q, done_d;
  logic        mem_we;
  logic [15:0] mem_q [32];

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_next;
  logic       error_q, error_d;

  assign sum_next = sum_q + byteIn;
  assign error    = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    hi_byte_d   = hi_byte_q;
    done_d      = done_q;
    mem_we      = 1'b0;
    byteReady   = 1'b0;
    loading     = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    error_d     = error_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRxHi;
          wr_ptr_d    = 5'd0;
          remaining_d = wordCountM1;
          done_d      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d       = 8'd0;
          error_d     = 1'b0;
`endif
        end
      end
      StRxHi: begin
        byteReady = 1'b1;
        loading   = 1'b1;
        if (byteValid) begin
          hi_byte_d = byteIn;
          state_d   = StRxLo;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d     = sum_next;
`endif
        end
      end
      StRxLo: begin
        byteReady = 1'b1;
        loading   = 1'b1;
        if (byteValid) begin
          mem_we = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d  = sum_next;
`endif
          if (remaining_q == 5'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
            done_d  = 1'b1;
`endif
          end else begin
            // remaining reaches 0 no later than wr_ptr reaches 31, so no wrap
            wr_ptr_d    = wr_ptr_q + 5'd1;
            remaining_d = remaining_q - 5'd1;
            state_d     = StRxHi;
          end
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      StCheck: begin
        byteReady = 1'b1;
        loading   = 1'b1;
        if (byteValid) begin
          state_d = StDone;
          done_d  = 1'b1;
          error_d = (sum_next != 8'd0);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= 5'd0;
      remaining_q <= 5'd0;
      hi_byte_q   <= 8'd0;
      done_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      hi_byte_q   <= hi_byte_d;
      done_q      <= done_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      error_q     <= error_d;
`endif
    end
  end

  // Reset clears the whole array so no partial program survives an aborted load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= {hi_byte_q, byteIn};
    end
  end

  assign instruction = mem_q[address];
  assign cpuHold     = loading;
  assign done        = done_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench for inst_mem_loader: byte-count reference model plus directed literal checks.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start = 1'b0;
  logic [4:0]  wordCountM1 = 5'd0;
  logic [7:0]  byteIn = 8'd0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [4:0]  address = 5'd0;
  logic [15:0] instruction;
  logic        loading, cpuHold, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  inst_mem_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .wordCountM1 (wordCountM1),
    .byteIn      (byteIn),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .address     (address),
    .instruction (instruction),
    .loading     (loading),
    .cpuHold     (cpuHold),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam int CksBytes = 1;
`else
  localparam int CksBytes = 0;
`endif

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a load is just a count of accepted bytes against an expected total.
  logic [15:0] m_mem [32];
  bit          m_loading = 1'b0;
  bit          m_done = 1'b0;
  bit          m_error = 1'b0;
  int          m_count = 0;
  int          m_words = 0;
  int          m_sum = 0;
  logic [7:0]  m_hi = 8'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
      m_loading = 1'b0;
      m_done    = 1'b0;
      m_error   = 1'b0;
      m_count   = 0;
      m_words   = 0;
      m_sum     = 0;
      m_hi      = 8'd0;
    end else if (!m_loading) begin
      if (start) begin
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_error   = 1'b0;
        m_count   = 0;
        m_sum     = 0;
        m_words   = int'(wordCountM1) + 1;
      end
    end else if (byteValid) begin
      if (m_count < 2 * m_words) begin
        if (m_count % 2 == 0) m_hi = byteIn;
        else m_mem[m_count / 2] = {m_hi, byteIn};
        m_sum = (m_sum + int'(byteIn)) % 256;
      end else begin
        m_error = ((m_sum + int'(byteIn)) % 256) != 0;
      end
      m_count++;
      if (m_count == 2 * m_words + CksBytes) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("instruction", instruction, m_mem[address]);
    check("byteReady", byteReady, m_loading);
    check("loading", loading, m_loading);
    check("cpuHold", cpuHold, m_loading);
    check("done", done, m_done);
    check("error", error, m_error);
  end

  logic [7:0] tx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input int a, input logic [15:0] exp);
    address = a[4:0];
    #1;
    check(name, instruction, exp);
  endtask

  task automatic add_cks(input bit good);
    int s = 0;
    foreach (tx[i]) s += int'(tx[i]);
    s = (256 - (s % 256)) % 256;
    if (!good) s = (s + 1 + int'($urandom_range(254))) % 256;
    if (CksBytes != 0) tx.push_back(s[7:0]);
  endtask

  // gap: 0 back-to-back, 1 bubble before every byte, 2 random bubbles and stray starts.
  task automatic run_load(input int nm1, input int gap, input int abort_after);
    start       = 1'b1;
    wordCountM1 = nm1[4:0];
    byteValid   = 1'($urandom);
    byteIn      = 8'($urandom);
    address     = 5'($urandom);
    tick();
    start = 1'b0;
    for (int i = 0; i < tx.size(); i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(2) == 0)) begin
        byteValid = 1'b0;
        byteIn    = 8'($urandom);
        tick();
      end
      byteValid = 1'b1;
      byteIn    = tx[i];
      address   = 5'($urandom);
      if (gap == 2 && $urandom_range(7) == 0) begin
        start       = 1'b1;
        wordCountM1 = 5'($urandom);
      end
      tick();
      start = 1'b0;
      if (i == abort_after) begin
        byteValid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_loading", loading, 1'b0);
        check("abort_cpuHold", cpuHold, 1'b0);
        address = 5'd0;
        #1;
        check("abort_mem0", instruction, 16'h0000);
        #2 reset_n = 1'b1;
        return;
      end
    end
    byteValid = 1'b0;
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      byteValid = 1'($urandom);
      byteIn    = 8'($urandom);
      address   = 5'($urandom);
      tick();
    end
    byteValid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    #1;
    check("reset_byteReady", byteReady, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_loading", loading, 1'b0);
    check("reset_error", error, 1'b0);
    for (int a = 0; a < 32; a++) peek("reset_mem", a, 16'h0000);
    #1 reset_n = 1'b1;
    tick();

    // Two words back-to-back.
    tx = '{8'h20, 8'h11, 8'h30, 8'h04};
    add_cks(1'b1);
    run_load(1, 0, -1);
    check("b2b_done", done, 1'b1);
    peek("b2b_mem0", 0, 16'h2011);
    peek("b2b_mem1", 1, 16'h3004);
    peek("b2b_mem2", 2, 16'h0000);
    idle_noise(3);

    // Same load with a bubble before every byte.
    run_load(1, 1, -1);
    check("gap_done", done, 1'b1);
    peek("gap_mem0", 0, 16'h2011);
    peek("gap_mem1", 1, 16'h3004);
    idle_noise(2);

    // Full 32-word load, word i = {i, ~i}.
    tx = {};
    for (int i = 0; i < 32; i++) begin
      tx.push_back(8'(i));
      tx.push_back(~8'(i));
    end
    add_cks(1'b1);
    run_load(31, 0, -1);
    tick();
    check("full_done", done, 1'b1);
    peek("full_mem31", 31, 16'h1FE0);
    peek("full_mem0", 0, 16'h00FF);
    idle_noise(2);

    // Reset after three of four bytes, then a clean load.
    tx = '{8'h20, 8'h11, 8'h30, 8'h04};
    add_cks(1'b1);
    run_load(1, 0, 2);
    tick();
    tx = '{8'hAB, 8'hCD};
    add_cks(1'b1);
    run_load(0, 0, -1);
    tick();
    check("reload_done", done, 1'b1);
    peek("reload_mem0", 0, 16'hABCD);
    peek("reload_mem1", 1, 16'h0000);

`ifdef INST_LOADER_CHECKSUM_EN
    tx = '{8'h12, 8'h34, 8'hBA};
    run_load(0, 0, -1);
    tick();
    check("cks_good_error", error, 1'b0);
    check("cks_good_done", done, 1'b1);
    tx = '{8'h12, 8'h34, 8'hBB};
    run_load(0, 0, -1);
    tick();
    check("cks_bad_error", error, 1'b1);
    check("cks_bad_done", done, 1'b1);
    peek("cks_bad_mem0", 0, 16'h1234);
`endif

    // Randomized loads with bubbles, stray starts, bad checksums and aborts.
    for (int n = 0; n < 30; n++) begin
      int nm1;
      int abort_at;
      nm1 = int'($urandom_range(31));
      tx = {};
      for (int i = 0; i < 2 * (nm1 + 1); i++) tx.push_back(8'($urandom));
      add_cks(1'($urandom_range(3) != 0));
      abort_at = ($urandom_range(7) == 0) ? int'($urandom_range(tx.size() - 1)) : -1;
      run_load(nm1, int'($urandom_range(2)), abort_at);
      idle_noise(int'($urandom_range(3)) + 1);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
